rr_onehot_arb: RTL and testbench
================================

# rr_onehot_arb

Round-robin arbiter that produces a registered one-hot grant vector from a multi-bit request vector. It holds each grant until the owner acknowledges it, or until an optional hold-timeout forces a release. It sits in front of shared resources such as issue ports, memory ports and writeback buses. Its `gnt` output is the one-hot source that downstream one-hot checks consume.

## Interface
Parameters:
- `WIDTH`, default 8: number of requesters; minimum 2.
- `MAX_HOLD`, default 0: maximum cycles a grant may be held. 0 means unlimited. Otherwise 1..255.

Ports:
- `clk`, input, 1: the only clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, WIDTH: request vector; bit i is requester i.
- `ack`, input, 1: the current owner releases the grant this cycle.
- `gnt`, output, WIDTH: one-hot grant, or zero when idle.
- `gnt_valid`, output, 1: equals OR of `gnt`.
- `gnt_idx`, output, $clog2(WIDTH): binary index of the granted bit. It is 0 when idle.
- `preempt`, output, 1: one-cycle pulse when a timeout forced the release.

## Operation
State machine:
- Two states: IDLE and BUSY.
- IDLE: if `req` is non-zero, pick a winner and go to BUSY. Otherwise stay in IDLE.
- BUSY: hold `gnt` unchanged regardless of `req`; a requester dropping its `req` does not revoke its grant.
- BUSY exits on `ack`, or on timeout when `MAX_HOLD` > 0 and the hold counter equals `MAX_HOLD`-1.

Release:
- On release, `ptr` becomes (granted idx + 1) mod WIDTH, wrapping WIDTH-1 to 0.
- If `req` with the released bit masked off is non-zero, grant the next winner directly and stay BUSY.
- Otherwise, if the released requester is still requesting, re-grant it.
- Otherwise go to IDLE.

Winner selection:
- The winner is the first set bit at or above `ptr`, searching upward with wrap-around.
- `ptr` resets to 0.

Hold counter:
- 8 bits wide.
- Cleared on every new grant; increments each BUSY cycle.
- Saturates; it never wraps.

Ignored inputs:
- `ack` in IDLE has no effect.
- `ack` in the same cycle as a timeout counts as a normal ack: `preempt` stays 0.

Invariants:
- `gnt` is always one-hot or zero.
- A newly issued grant is always a subset of the `req` sampled in the decision cycle.

## Timing
- All outputs are registered. After reset: `gnt`=0, `gnt_valid`=0, `gnt_idx`=0, `preempt`=0, `ptr`=0, state IDLE.
- Grant latency: `req` is non-zero in cycle N while IDLE, so `gnt` is valid in N+1.
- Handover: `ack` in cycle M gives the new `gnt` in M+1, with no idle bubble.
- Release to idle: `gnt`=0 in M+1 when nothing remains to grant.
- Timeout: with `MAX_HOLD`=K, a grant that first appears in cycle G is released at the edge ending cycle G+K-1. `preempt`=1 in cycle G+K only.
- Reset asserted mid-grant clears every output immediately, without waiting for a clock edge. The first grant after reset deassertion follows the grant-latency rule.

## Configuration
- Macro `RR_ONEHOT_ARB_CHECK_EN`.
- Defined: concurrent assertions, disabled while `rst`=1, check four things. `gnt` is one-hot or zero. `gnt_valid` equals OR of `gnt`. `gnt_idx` matches `gnt`. Each new grant bit was set in `req` the previous cycle. Each failure reports `$error` naming the failed check.
- Not defined: no assertion code is compiled; behaviour and ports are identical.

## Structure
- Package `arb_pkg` holds:
  - the state enum `arb_state_e` (ARB_IDLE, ARB_BUSY);
  - the `arb_hold_cnt_t` 8-bit typedef;
  - the localparam `ARB_MAX_HOLD_LIMIT` = 255.
- One sub-module, `rr_prio_pick` (combinational). Inputs: `req`, `ptr`. Outputs: one-hot `pick`, binary `pick_idx`, `any`. It uses a double-width rotate-and-find-first.
- The top level holds the FSM, `ptr`, the hold counter and the output registers.

## Test plan
All scenarios use `WIDTH`=4.
- Reset then `req`=4'b0110 in cycle 1 gives `gnt`=4'b0010 and `gnt_idx`=1 in cycle 2. `ack` in cycle 3 gives `gnt`=4'b0100 in cycle 4 with no zero cycle between.
- `req`=4'b1111 held, ack every cycle: grants go 0001, 0010, 0100, 1000, 0001, which checks the wrap.
- Single requester `req`=4'b1000 held with ack every cycle: `gnt` stays 4'b1000 continuously.
- `MAX_HOLD`=3, `req`=4'b0011, never ack: `gnt` 0001 lasts 3 cycles, then 0010 with `preempt`=1 for one cycle, then repeats.
- Grant 4'b0100 active, `req` drops to 0: `gnt` holds until `ack`, then goes to 0 and `gnt_valid`=0 the next cycle. A stray `ack` while idle changes nothing.
- Assert `rst` between edges while `gnt`=4'b1000: outputs are 0 before the next edge. After release, `req`=4'b1001 grants 4'b0001 because `ptr` is back to 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
// Used by rr_onehot_arb and rr_prio_pick.
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    typedef logic [7:0] arb_hold_cnt_t;

    localparam int ARB_MAX_HOLD_LIMIT = 255;

    // A hold limit of zero never expires; otherwise expiry is on the last allowed cycle.
    function automatic logic hold_expired(input arb_hold_cnt_t cnt, input int unsigned max_hold);
        return (max_hold != 0) && (cnt == arb_hold_cnt_t'(max_hold - 1));
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational round-robin pick: first set request bit at or above ptr, wrapping.
// Rotates the request vector down by ptr, finds the lowest set bit, then maps back.
module rr_prio_pick
    import arb_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [WIDTH-1:0] pick,
    output logic [IDX_W-1:0] pick_idx,
    output logic             any
);

    logic [WIDTH-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Bit i of rot is req[(ptr + i) mod WIDTH]; ptr < WIDTH keeps the shift in range.
    assign rot = WIDTH'({req, req} >> ptr);
    assign any = |req;

    always_comb begin
        off = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign sum      = {1'b0, ptr} + {1'b0, off};
    assign pick_idx = (sum >= (IDX_W + 1)'(WIDTH)) ? IDX_W'(sum - (IDX_W + 1)'(WIDTH))
                                                   : sum[IDX_W-1:0];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pick
            assign pick[gi] = any && (pick_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_onehot_arb.sv
// Round-robin arbiter with registered one-hot grant, ack-based release and optional hold timeout.
// Define RR_ONEHOT_ARB_CHECK_EN to compile the built-in grant consistency assertions.
module rr_onehot_arb
    import arb_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 0,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] req,
    input  logic             ack,
    output logic [WIDTH-1:0] gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             preempt
);

    arb_state_e    state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg, ptr_next, ptr_after;
    arb_hold_cnt_t hold_cnt_reg, hold_cnt_next;
    logic [WIDTH-1:0] gnt_reg, gnt_next;
    logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
    logic          gnt_valid_reg, gnt_valid_next;
    logic          preempt_reg, preempt_next;

    logic [WIDTH-1:0] pick_req, pick;
    logic [IDX_W-1:0] pick_ptr, pick_idx;
    logic          pick_any;
    logic          timeout, rel, regrant;

    assign ptr_after = (gnt_idx_reg == IDX_W'(WIDTH - 1)) ? '0 : gnt_idx_reg + 1'b1;
    assign timeout   = hold_expired(hold_cnt_reg, MAX_HOLD);
    assign rel       = (state_reg == ARB_BUSY) && (ack || timeout);
    assign regrant   = req[gnt_idx_reg];

    // While busy the picker looks at the other requesters from the post-release pointer.
    always_comb begin
        pick_req = req;
        pick_ptr = ptr_reg;
        if (state_reg == ARB_BUSY) begin
            pick_req = req & ~gnt_reg;
            pick_ptr = ptr_after;
        end
    end

    rr_prio_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .req      (pick_req),
        .ptr      (pick_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_next = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (rel && !pick_any && !regrant) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_next      = gnt_reg;
        gnt_idx_next  = gnt_idx_reg;
        ptr_next      = ptr_reg;
        preempt_next  = 1'b0;
        hold_cnt_next = hold_cnt_reg;
        if ((state_reg == ARB_BUSY) && (hold_cnt_reg != arb_hold_cnt_t'(ARB_MAX_HOLD_LIMIT))) begin
            hold_cnt_next = hold_cnt_reg + 1'b1;
        end
        case (state_reg)
            ARB_IDLE: begin
                if (pick_any) begin
                    gnt_next      = pick;
                    gnt_idx_next  = pick_idx;
                    hold_cnt_next = '0;
                end
            end
            ARB_BUSY: begin
                if (rel) begin
                    ptr_next     = ptr_after;
                    preempt_next = !ack;
                    if (pick_any) begin
                        gnt_next      = pick;
                        gnt_idx_next  = pick_idx;
                        hold_cnt_next = '0;
                    end else if (regrant) begin
                        hold_cnt_next = '0;
                    end else begin
                        gnt_next     = '0;
                        gnt_idx_next = '0;
                    end
                end
            end
            default: begin
                gnt_next     = '0;
                gnt_idx_next = '0;
            end
        endcase
        gnt_valid_next = |gnt_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg       <= '0;
            hold_cnt_reg  <= '0;
            gnt_reg       <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
        end else begin
            ptr_reg       <= ptr_next;
            hold_cnt_reg  <= hold_cnt_next;
            gnt_reg       <= gnt_next;
            gnt_idx_reg   <= gnt_idx_next;
            gnt_valid_reg <= gnt_valid_next;
            preempt_reg   <= preempt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign preempt   = preempt_reg;

`ifdef RR_ONEHOT_ARB_CHECK_EN
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt))
        else $error("gnt_onehot check failed: gnt=%b", gnt);
    a_gnt_valid: assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt))
        else $error("gnt_valid check failed: gnt=%b gnt_valid=%b", gnt, gnt_valid);
    a_gnt_idx: assert property (@(posedge clk) disable iff (rst)
        (gnt_valid ? (gnt == (WIDTH'(1) << gnt_idx)) : (gnt_idx == '0)))
        else $error("gnt_idx check failed: gnt=%b gnt_idx=%0d", gnt, gnt_idx);
    a_gnt_subset: assert property (@(posedge clk) disable iff (rst)
        ((gnt & ~$past(gnt) & ~$past(req)) == '0))
        else $error("gnt_subset check failed: gnt=%b", gnt);
`endif

endmodule

// File: tb/tb_rr_onehot_arb.sv
// Directed plus random bench for rr_onehot_arb at WIDTH=4, with MAX_HOLD=0 and MAX_HOLD=3 instances
// checked cycle by cycle against a behavioural owner/pointer model.
module tb_rr_onehot_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       ack = 1'b0;

    logic [3:0] gnt0, gnt3;
    logic       gv0, gv3, pr0, pr3;
    logic [1:0] gi0, gi3;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: current owner (-1 idle), round-robin pointer, cycles held, preempt pulse.
    int   m_own[2];
    int   m_ptr[2];
    int   m_held[2];
    logic m_pre[2];
    int   mh[2];

    always #5 clk = ~clk;

    rr_onehot_arb #(.WIDTH(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(gnt0), .gnt_valid(gv0), .gnt_idx(gi0), .preempt(pr0)
    );

    rr_onehot_arb #(.WIDTH(4), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .gnt(gnt3), .gnt_valid(gv3), .gnt_idx(gi3), .preempt(pr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find_from(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_own[m]  = -1;
            m_ptr[m]  = 0;
            m_held[m] = 0;
            m_pre[m]  = 1'b0;
        end
    endtask

    task automatic model_step(input int m, input logic [3:0] r, input logic a);
        int  w;
        logic expired;
        m_pre[m] = 1'b0;
        if (m_own[m] < 0) begin
            w = find_from(r, m_ptr[m]);
            if (w >= 0) begin
                m_own[m]  = w;
                m_held[m] = 0;
            end
        end else begin
            expired = (mh[m] > 0) && (m_held[m] + 1 >= mh[m]);
            if (a || expired) begin
                m_pre[m] = !a;
                m_ptr[m] = (m_own[m] + 1) % 4;
                w = find_from(r & ~(4'b0001 << m_own[m]), m_ptr[m]);
                if (w >= 0) begin
                    m_own[m]  = w;
                    m_held[m] = 0;
                end else if (r[m_own[m]]) begin
                    m_held[m] = 0;
                end else begin
                    m_own[m] = -1;
                end
            end else begin
                m_held[m]++;
            end
        end
    endtask

    task automatic check_model(input int m, input string pfx, input logic [3:0] g,
                               input logic gv, input logic [1:0] gi, input logic pr);
        logic [3:0] eg;
        eg = (m_own[m] < 0) ? 4'b0000 : (4'b0001 << m_own[m]);
        chk({pfx, ".gnt"}, 32'(g), 32'(eg));
        chk({pfx, ".gnt_valid"}, 32'(gv), 32'(m_own[m] >= 0));
        chk({pfx, ".gnt_idx"}, 32'(gi), (m_own[m] < 0) ? 32'd0 : 32'(m_own[m]));
        chk({pfx, ".preempt"}, 32'(pr), 32'(m_pre[m]));
    endtask

    task automatic cycle(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        model_step(0, r, a);
        model_step(1, r, a);
        #1;
        cyc++;
        $display("cyc %0d req=%b ack=%b | gnt0=%b idx0=%0d pre0=%b | gnt3=%b idx3=%0d pre3=%b",
                 cyc, r, a, gnt0, gi0, pr0, gnt3, gi3, pr3);
        check_model(0, "dut0", gnt0, gv0, gi0, pr0);
        check_model(1, "dut3", gnt3, gv3, gi3, pr3);
    endtask

    initial begin
        mh[0] = 0;
        mh[1] = 3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_model(0, "reset.dut0", gnt0, gv0, gi0, pr0);
        check_model(1, "reset.dut3", gnt3, gv3, gi3, pr3);

        // Grant latency and handover without an idle bubble.
        cycle(4'b0110, 1'b0);
        chk("first_gnt", 32'(gnt0), 32'b0010);
        chk("first_idx", 32'(gi0), 32'd1);
        cycle(4'b0110, 1'b0);
        cycle(4'b0110, 1'b1);
        chk("handover_gnt", 32'(gnt0), 32'b0100);

        // Requester drops but keeps its grant until ack; then stray acks while idle.
        repeat (3) cycle(4'b0000, 1'b0);
        chk("hold_after_drop", 32'(gnt0), 32'b0100);
        cycle(4'b0000, 1'b1);
        chk("release_idle_gnt", 32'(gnt0), 32'b0000);
        chk("release_idle_valid", 32'(gv0), 32'd0);
        repeat (2) cycle(4'b0000, 1'b1);
        chk("stray_ack_gnt", 32'(gnt0), 32'b0000);

        // Full request with ack every cycle walks the pointer with wrap.
        repeat (6) cycle(4'b1111, 1'b1);

        // Lone requester is re-granted continuously.
        for (int i = 0; i < 4; i++) begin
            cycle(4'b1000, 1'b1);
            chk("lone_regrant", 32'(gnt0), 32'b1000);
        end

        // No acks: dut3 rotates by timeout, dut0 holds.
        repeat (12) cycle(4'b0011, 1'b0);

        // Asynchronous reset mid-grant.
        cycle(4'b1000, 1'b1);
        chk("pre_reset_gnt", 32'(gnt0), 32'b1000);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_gnt0", 32'(gnt0), 32'd0);
        chk("async_rst_valid0", 32'(gv0), 32'd0);
        chk("async_rst_idx0", 32'(gi0), 32'd0);
        chk("async_rst_gnt3", 32'(gnt3), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(4'b1001, 1'b0);
        chk("post_reset_gnt0", 32'(gnt0), 32'b0001);
        chk("post_reset_gnt3", 32'(gnt3), 32'b0001);

        // Random traffic against the model.
        repeat (300) cycle(4'($urandom), $urandom_range(0, 3) == 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
